// File: rtl/exponential_pkg.sv
// Shared definitions for the fixed-point e^x calculator.
//   X_W     operand width, unsigned Q0.16
//   PW_W    power-of-x register width, Q1.16
//   ACC_W   accumulator / result width, Q2.16
//   K_W     iteration counter width
//   state_e controller states
//   coef_lookup returns 1/k! in Q1.16 for k = 1..7
package exponential_pkg;

  localparam int unsigned X_W   = 16;
  localparam int unsigned PW_W  = 17;
  localparam int unsigned ACC_W = 18;
  localparam int unsigned K_W   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCalc,
    StDone
  } state_e;

  // Index 0 is never used by the series; it reads as zero.
  localparam logic [PW_W-1:0] COEF_ROM [8] = '{
    17'h00000, 17'h10000, 17'h08000, 17'h02AAB,
    17'h00AAB, 17'h00222, 17'h0005B, 17'h0000D
  };

  function automatic logic [PW_W-1:0] coef_lookup(input logic [K_W-1:0] k);
    return COEF_ROM[k];
  endfunction

endpackage

// File: rtl/exponential_datapath.sv
// Taylor-series datapath: holds the latched operand, the running power x^k, the
// accumulated sum and the term index. One series term is added per i_calc cycle.
//   clk      system clock, rising edge
//   rst      synchronous active-high reset, clears every register
//   i_load   latch i_x and initialise pw = acc = 1.0, k = 1
//   i_calc   perform one series iteration
//   i_x      operand, unsigned Q0.16
//   o_acc    accumulated result, Q2.16
//   o_k      current term index
module exponential_datapath
  import exponential_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_calc,
  input  logic [X_W-1:0]   i_x,
  output logic [ACC_W-1:0] o_acc,
  output logic [K_W-1:0]   o_k
);

  localparam int unsigned PowProdW  = X_W + PW_W;
  localparam int unsigned TermProdW = 2 * PW_W;

  logic [X_W-1:0]       r_xr;
  logic [PW_W-1:0]      r_pw;
  logic [ACC_W-1:0]     r_acc;
  logic [K_W-1:0]       r_k;

  logic [PowProdW-1:0]  w_pw_prod;
  logic [PW_W-1:0]      w_pw_next;
  logic [PW_W-1:0]      w_coef;
  logic [TermProdW-1:0] w_term_prod;
  logic [ACC_W-1:0]     w_term;
  logic [ACC_W-1:0]     w_acc_next;

  // x^k = (x^(k-1) * x) >> 16; pw never exceeds 1.0 so 17 bits suffice.
  assign w_pw_prod   = {{X_W{1'b0}}, r_pw} * {{PW_W{1'b0}}, r_xr};
  assign w_pw_next   = PW_W'(w_pw_prod >> X_W);

  assign w_coef      = coef_lookup(r_k);
  assign w_term_prod = {{PW_W{1'b0}}, w_pw_next} * {{PW_W{1'b0}}, w_coef};
  assign w_term      = ACC_W'(w_term_prod >> X_W);

  // The sum stays below e < 4, so the 18-bit add cannot wrap.
  assign w_acc_next  = r_acc + w_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xr  <= '0;
      r_pw  <= '0;
      r_acc <= '0;
      r_k   <= '0;
    end else if (i_load) begin
      r_xr  <= i_x;
      r_pw  <= 17'h10000;
      r_acc <= 18'h10000;
      r_k   <= 3'd1;
    end else if (i_calc) begin
      r_pw  <= w_pw_next;
      r_acc <= w_acc_next;
      r_k   <= r_k + 3'd1;
    end
  end

  assign o_acc = r_acc;
  assign o_k   = r_k;

endmodule

// File: rtl/exponential.sv
// Start/done accelerator computing e^x by a truncated Taylor series, one term
// per clock. Result is Q2.16 split into integer and fractional parts.
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any calculation
//   start     level request, honoured only when idle or done
//   x         operand, unsigned Q0.16, latched on accept
//   done      high while the result is valid, held until the next accept
//   intpart   result bits 17:16
//   fracpart  result bits 15:0
module exponential
  import exponential_pkg::*;
#(
  parameter int unsigned N_TERMS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x,
  output logic           done,
  output logic [1:0]     intpart,
  output logic [15:0]    fracpart
);

  localparam logic [K_W-1:0] LastK = K_W'(N_TERMS - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_load;
  logic             w_calc;
  logic [ACC_W-1:0] w_acc;
  logic [K_W-1:0]   w_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_calc       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_next = StLoad;
      end
      StLoad: begin
        w_load       = 1'b1;
        w_state_next = StCalc;
      end
      StCalc: begin
        w_calc = 1'b1;
        if (w_k == LastK) w_state_next = StDone;
      end
      StDone: begin
        if (start) w_state_next = StLoad;
      end
      default: w_state_next = StIdle;
    endcase
  end

  exponential_datapath u_datapath (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_calc (w_calc),
    .i_x    (x),
    .o_acc  (w_acc),
    .o_k    (w_k)
  );

  assign done     = (r_state == StDone);
  assign intpart  = w_acc[17:16];
  assign fracpart = w_acc[15:0];

endmodule

// File: tb/tb_exponential.sv
module tb_exponential;

  localparam int N_TERMS = 8;
  localparam int LATENCY = N_TERMS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x = '0;
  logic        done;
  logic [1:0]  intpart;
  logic [15:0] fracpart;

  exponential #(.N_TERMS(N_TERMS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .done     (done),
    .intpart  (intpart),
    .fracpart (fracpart)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-exact series evaluation straight from the arithmetic rules.
  function automatic logic [17:0] exp_model(input logic [15:0] xv);
    longint unsigned coef [8] = '{64'h0, 64'h10000, 64'h8000, 64'h2AAB,
                                  64'hAAB, 64'h222, 64'h5B, 64'hD};
    longint unsigned pw  = 64'h10000;
    longint unsigned acc = 64'h10000;
    for (int k = 1; k < N_TERMS; k++) begin
      pw  = ((pw * longint'(xv)) >> 16) & 64'h1FFFF;
      acc = (acc + ((pw * coef[k]) >> 16)) & 64'h3FFFF;
    end
    return acc[17:0];
  endfunction

  function automatic bit in_window(input logic [17:0] v, input int centre);
    return (int'(v) >= centre - 16) && (int'(v) <= centre + 16);
  endfunction

  // Timing model: edge count of the last accept; the result is due LATENCY edges later.
  int          edge_no    = 0;
  int          m_acc_edge = -1;
  bit          m_seen_rst = 1'b0;
  logic [17:0] m_result   = '0;
  bit          exp_done;

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      m_seen_rst = 1'b1;
      m_acc_edge = -1;
      m_result   = '0;
    end else if (m_seen_rst && start &&
                 (m_acc_edge < 0 || edge_no >= m_acc_edge + LATENCY + 1)) begin
      m_acc_edge = edge_no;
      m_result   = exp_model(x);
    end
  end

  always @(negedge clk) begin
    if (m_seen_rst) begin
      exp_done = (m_acc_edge >= 0) && (edge_no >= m_acc_edge + LATENCY);
      check("done_track", done === exp_done, done, exp_done);
      if (m_acc_edge < 0 || exp_done)
        check("result_track", {intpart, fracpart} === m_result, {intpart, fracpart}, m_result);
    end
  end

  task automatic run_op(input logic [15:0] xv, input int hold, output logic [17:0] res,
                        output int lat);
    @(negedge clk);
    x     = xv;
    start = 1'b1;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == hold) start = 1'b0;
      if (done) begin
        lat = i - 1;
        break;
      end
    end
    start = 1'b0;
    res   = {intpart, fracpart};
    check("latency", lat == LATENCY, lat, LATENCY);
    check("bit_exact", res === exp_model(xv), res, exp_model(xv));
  endtask

  task automatic check_real(input logic [15:0] xv, input logic [17:0] res);
    real t, d;
    t = $exp(real'(xv) / 65536.0) * 65536.0;
    d = real'(res) - t;
    if (d < 0.0) d = -d;
    check("accuracy", d <= 16.0, res, longint'($rtoi(t)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [17:0] res;
  int          lat;
  logic [15:0] xv;

  initial begin
    // Reset and idle.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_done", done === 1'b0, done, 0);
    check("reset_value", {intpart, fracpart} === 18'h0, {intpart, fracpart}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done", done === 1'b0, done, 0);

    // Pin the model to hand-derived values.
    check("model_x0", exp_model(16'h0000) == 18'h10000, exp_model(16'h0000), 18'h10000);
    check("model_xffff", in_window(exp_model(16'hFFFF), 'h2B7DF), exp_model(16'hFFFF), 'h2B7DF);
    check("model_x8000", in_window(exp_model(16'h8000), 'h1A612), exp_model(16'h8000), 'h1A612);
    check("model_x4000", in_window(exp_model(16'h4000), 'h148B5), exp_model(16'h4000), 'h148B5);

    // Largest operand, start held three cycles.
    run_op(16'hFFFF, 3, res, lat);
    check("xffff_int", res[17:16] == 2'd2, res[17:16], 2);
    check("xffff_window", in_window(res, 'h2B7DF), res, 'h2B7DF);
    repeat (4) @(negedge clk);
    check("xffff_hold", done === 1'b1, done, 1);

    run_op(16'h0000, 1, res, lat);
    check("x0_exact", res == 18'h10000, res, 18'h10000);

    run_op(16'h8000, 1, res, lat);
    check("x8000_window", in_window(res, 'h1A612), res, 'h1A612);
    run_op(16'h4000, 2, res, lat);
    check("x4000_window", in_window(res, 'h148B5), res, 'h148B5);

    // Reset during the fourth CALC cycle.
    @(negedge clk);
    x     = 16'hC000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", done === 1'b0, done, 0);
    check("abort_value", {intpart, fracpart} === 18'h0, {intpart, fracpart}, 0);
    run_op(16'h1234, 1, res, lat);
    check_real(16'h1234, res);

    // Random sweep.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       xv = 16'h0000;
        1:       xv = 16'hFFFF;
        default: xv = 16'($urandom);
      endcase
      run_op(xv, $urandom_range(1, 4), res, lat);
      check_real(xv, res);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
